multicycle_main_fsm: RTL
========================

Name: multicycle_main_fsm

Overview:
- Main control state machine for the multicycle ARMv4 core.
- Sequences fetch, decode, execute, memory access and writeback over several cycles.
- Drives the mux selects, write enables and the ALUOp qualifier consumed by the ALU decoder.
- Stalls on a memory-ready handshake. Condition-check gating of RegW, MemW and Branch is done downstream, not here.

Parameters:
ILLEGAL_HALT, 1, when 1 an illegal Op (2'b11) parks the FSM in HALT until reset; when 0 it returns to FETCH.

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high reset
Op  in  2  instruction class from Instr[27:26] (00 data-processing, 01 memory, 10 branch)
Funct  in  6  Instr[25:20]; [5] immediate flag, [4:1] cmd, [0] S/L bit
mem_ready  in  1  memory has completed the current access this cycle
IRWrite  out  1  load instruction register
NextPC  out  1  PC update enable (PC+4)
AdrSrc  out  1  memory address select: 0 PC, 1 ALU result
ALUSrcA  out  1  0 register A, 1 PC
ALUSrcB  out  2  00 register B, 01 extended immediate, 10 constant 4
ResultSrc  out  2  00 ALUOut, 01 read data, 10 ALU result
ALUOp  out  1  1 means the ALU decoder decodes Funct; 0 forces ADD
RegW  out  1  register-file write request (pre-condition)
MemW  out  1  memory write request (pre-condition)
Branch  out  1  branch request (pre-condition)
halted  out  1  FSM is in HALT
state_o  out  4  current state encoding, for debug and bench

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, HALT=15. Any other value recovers to FETCH on the next edge.
- Reset:
  - State goes to FETCH asynchronously.
  - While reset is high, IRWrite, NextPC, RegW, MemW and Branch are forced to 0.
  - All other outputs take their FETCH values; halted=0.
- Outputs are Moore decodes of state, except IRWrite and NextPC, which are also gated by mem_ready.
- Output values per state (all unlisted outputs are 0):
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10; IRWrite=NextPC=mem_ready.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, ResultSrc=00, MemW=1. MemW is held for every wait cycle.
  - EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1.
  - HALT: all enables 0; halted=1.
- Transitions:
  - FETCH -> DECODE when mem_ready, else stay.
  - DECODE on Op:
    - 00: EXECI if Funct[5], else EXECR.
    - 01: MEMADR.
    - 10: BRANCH.
    - 11: HALT if ILLEGAL_HALT, else FETCH.
  - MEMADR -> MEMRD if Funct[0], else MEMWR.
  - MEMRD -> MEMWB when mem_ready, else stay.
  - MEMWR -> FETCH when mem_ready, else stay.
  - EXECR/EXECI -> FETCH if Funct[4:1]==4'b1010 (CMP, no writeback), else ALUWB.
  - MEMWB, ALUWB, BRANCH -> FETCH.
  - HALT -> HALT.
- Op and Funct are sampled each cycle from the IR; they are stable from DECODE onward.
- Latency with mem_ready tied high: DP 4 cycles (CMP 3), LDR 5, STR 4, B 3.
- Reset asserted mid-instruction aborts it immediately; no partial RegW/MemW is issued after reset rises.

Decomposition:
- Package multicycle_pkg holds:
  - the state_t enum with the encodings above;
  - select constants: SRCB_REG/IMM/FOUR and RES_ALUOUT/RDATA/ALU;
  - the CMP command constant 4'b1010.
- One sub-module, main_fsm_outdec: purely combinational state -> control-vector decode. Keeps the sequential part minimal.

Test Plan:
- Reset mid-MEMWR (MemW=1), assert reset -> same cycle MemW=0, state_o=0. After release, FETCH with IRWrite=0 until mem_ready=1.
- ADD reg: Op=00, Funct=001000, mem_ready=1 -> state_o 0,1,6,8,0. ALUOp=1 only in cycle 3, RegW=1 only in cycle 4, IRWrite=NextPC=1 only in cycle 1.
- CMP imm: Op=00, Funct=110101 -> state_o 0,1,7,0. RegW never 1. ALUSrcB=01 in EXECI.
- LDR with stall: Op=01, Funct=011001, mem_ready low 2 cycles in FETCH and 3 in MEMRD -> FETCH held 3 cycles with IRWrite=0 until the ready cycle. MEMRD held 4 cycles. Exactly one MEMWB cycle with ResultSrc=01, RegW=1.
- STR: Op=01, Funct=011000, mem_ready low 1 cycle in MEMWR -> MemW=1 for 2 consecutive cycles, AdrSrc=1, then FETCH.
- Branch and illegal: Op=10 -> 0,1,9,0 with Branch=1 in BRANCH. Op=11 with ILLEGAL_HALT=1 -> state_o=15, halted=1, held 20 cycles. With ILLEGAL_HALT=0 -> returns to FETCH.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multicycle ARMv4 main control FSM:
// state encodings, datapath select codes and the packed control vector.
package multicycle_pkg;

  // Main FSM states; encodings are visible on state_o for debug.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_HALT   = 4'd15
  } state_t;

  // ALU operand B select.
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result bus select.
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Instruction classes from Instr[27:26].
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  // Data-processing compare command: sets flags only, no register writeback.
  localparam logic [3:0] CMD_CMP = 4'b1010;

  // Control vector produced by the output decoder.
  typedef struct packed {
    logic       ir_write;
    logic       next_pc;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       halted;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // All-inactive control vector, the starting point of every decode.
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c = '0;
    return c;
  endfunction

endpackage

// File: rtl/main_fsm_outdec.sv
// Combinational state -> control-vector decode for the main FSM.
// Moore outputs, except IRWrite/NextPC in FETCH which follow mem_ready.
module main_fsm_outdec
  import multicycle_pkg::*;
(
  input  logic [3:0]        i_state,
  input  logic              i_mem_ready,
  output logic [CTRL_W-1:0] o_ctrl
);

  ctrl_t w_ctrl;

  // Decode the current state into datapath selects and enables.
  always_comb begin
    w_ctrl = ctrl_idle();
    case (i_state)
      S_FETCH: begin
        w_ctrl.adr_src    = 1'b0;
        w_ctrl.alu_src_a  = 1'b1;
        w_ctrl.alu_src_b  = SRCB_FOUR;
        w_ctrl.result_src = RES_ALU;
        // Latch the instruction and bump the PC only once memory delivers it.
        w_ctrl.ir_write   = i_mem_ready;
        w_ctrl.next_pc    = i_mem_ready;
      end
      S_DECODE: begin
        // Precompute PC+8 on the ALU while the register file is read.
        w_ctrl.alu_src_a  = 1'b1;
        w_ctrl.alu_src_b  = SRCB_FOUR;
        w_ctrl.result_src = RES_ALU;
      end
      S_MEMADR: begin
        w_ctrl.alu_src_a  = 1'b0;
        w_ctrl.alu_src_b  = SRCB_IMM;
      end
      S_MEMRD: begin
        w_ctrl.adr_src    = 1'b1;
        w_ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        w_ctrl.result_src = RES_RDATA;
        w_ctrl.reg_w      = 1'b1;
      end
      S_MEMWR: begin
        // MemW stays asserted for every cycle the memory holds us here.
        w_ctrl.adr_src    = 1'b1;
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.mem_w      = 1'b1;
      end
      S_EXECR: begin
        w_ctrl.alu_src_a  = 1'b0;
        w_ctrl.alu_src_b  = SRCB_REG;
        w_ctrl.alu_op     = 1'b1;
      end
      S_EXECI: begin
        w_ctrl.alu_src_a  = 1'b0;
        w_ctrl.alu_src_b  = SRCB_IMM;
        w_ctrl.alu_op     = 1'b1;
      end
      S_ALUWB: begin
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.reg_w      = 1'b1;
      end
      S_BRANCH: begin
        w_ctrl.alu_src_a  = 1'b0;
        w_ctrl.alu_src_b  = SRCB_IMM;
        w_ctrl.result_src = RES_ALU;
        w_ctrl.branch     = 1'b1;
      end
      S_HALT: begin
        w_ctrl.halted     = 1'b1;
      end
      default: begin
        // Unused encodings drive nothing; the FSM recovers on the next edge.
        w_ctrl = ctrl_idle();
      end
    endcase
  end

  assign o_ctrl = w_ctrl;

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle ARMv4 core: fetch, decode, execute,
// memory access and writeback, stalling on mem_ready. Condition gating of
// RegW/MemW/Branch happens downstream.
module multicycle_main_fsm
  import multicycle_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       halted,
  output logic [3:0] state_o
);

  state_t            r_state;
  state_t            w_state_next;
  logic [CTRL_W-1:0] w_ctrl_bits;
  ctrl_t             w_ctrl;

  // State register; reset drops straight back to FETCH, aborting any access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state selection from the current state, instruction fields and memory handshake.
  always_comb begin
    w_state_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_DP:   w_state_next = Funct[5] ? S_EXECI : S_EXECR;
          OP_MEM:  w_state_next = S_MEMADR;
          OP_BR:   w_state_next = S_BRANCH;
          default: w_state_next = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR: w_state_next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_state_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_state_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECR,
      S_EXECI:  w_state_next = (Funct[4:1] == CMD_CMP) ? S_FETCH : S_ALUWB;
      S_MEMWB,
      S_ALUWB,
      S_BRANCH: w_state_next = S_FETCH;
      S_HALT:   w_state_next = S_HALT;
      default:  w_state_next = S_FETCH;
    endcase
  end

  main_fsm_outdec u_outdec (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .o_ctrl      (w_ctrl_bits)
  );

  assign w_ctrl = ctrl_t'(w_ctrl_bits);

  // Drive outputs from the decoded vector; enables are squashed while reset is high.
  always_comb begin
    IRWrite   = w_ctrl.ir_write & ~reset;
    NextPC    = w_ctrl.next_pc  & ~reset;
    AdrSrc    = w_ctrl.adr_src;
    ALUSrcA   = w_ctrl.alu_src_a;
    ALUSrcB   = w_ctrl.alu_src_b;
    ResultSrc = w_ctrl.result_src;
    ALUOp     = w_ctrl.alu_op;
    RegW      = w_ctrl.reg_w    & ~reset;
    MemW      = w_ctrl.mem_w    & ~reset;
    Branch    = w_ctrl.branch   & ~reset;
    halted    = w_ctrl.halted;
    state_o   = r_state;
  end

endmodule
